// File: rtl/nucleic_acid_sequencer_if.sv
// Host-side configuration/handshake and reactor valve outputs of the nucleic-acid sequencer.
// WASH_REPEAT_EN adds the cfg_wash_reps input.
interface nucleic_acid_sequencer_if #(
  parameter int N_CH  = 12,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_load_len;
  logic [CNT_W-1:0] cfg_lysis_len;
  logic [CNT_W-1:0] cfg_mix_len;
  logic [CNT_W-1:0] cfg_trap_len;
  logic [CNT_W-1:0] cfg_wash_len;
  logic [CNT_W-1:0] cfg_elute_len;
  logic [CNT_W-1:0] cfg_collect_len;
  logic [N_CH-1:0]  ch_mask;
`ifdef WASH_REPEAT_EN
  logic [3:0]       cfg_wash_reps;
`endif
  logic             lysis_ctl;
  logic             wash_ctl;
  logic             elute_ctl;
  logic             horiz_ctl;
  logic             vertical_ctl;
  logic             loop_exit_ctl;
  logic             bead_vtl_ctl;
  logic             bead_trap_ctl;
  logic             waste_ctl;
  logic [N_CH-1:0]  collect_ctl;
  logic [2:0]       pump;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [3:0]       state_o;

  modport master (
`ifdef WASH_REPEAT_EN
    output cfg_wash_reps,
`endif
    output start, abort, cfg_load_len, cfg_lysis_len, cfg_mix_len, cfg_trap_len,
           cfg_wash_len, cfg_elute_len, cfg_collect_len, ch_mask,
    input  lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, loop_exit_ctl,
           bead_vtl_ctl, bead_trap_ctl, waste_ctl, collect_ctl, pump, busy, done,
           aborted, state_o
  );

  modport slave (
`ifdef WASH_REPEAT_EN
    input  cfg_wash_reps,
`endif
    input  start, abort, cfg_load_len, cfg_lysis_len, cfg_mix_len, cfg_trap_len,
           cfg_wash_len, cfg_elute_len, cfg_collect_len, ch_mask,
    output lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, loop_exit_ctl,
           bead_vtl_ctl, bead_trap_ctl, waste_ctl, collect_ctl, pump, busy, done,
           aborted, state_o
  );
endinterface

// File: rtl/nucleic_acid_sequencer.sv
// Step controller for the extraction reactor array: shared valves, per-channel collect walk, 6-phase pump.
// Optional WASH_REPEAT_EN: cfg_wash_reps repeats WASH with one closed-valve cycle between passes.
module nucleic_acid_sequencer #(
  parameter int N_CH     = 12,
  parameter int CNT_W    = 16,
  parameter int PUMP_DIV = 4
) (
  input logic clk,
  input logic rst,
  nucleic_acid_sequencer_if.slave bus
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(N_CH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PUMP_DIV - 1);

  localparam logic [8:0] V_LYSIS = 9'b1_0000_0000;
  localparam logic [8:0] V_WASH  = 9'b0_1000_0000;
  localparam logic [8:0] V_ELUTE = 9'b0_0100_0000;
  localparam logic [8:0] V_HORIZ = 9'b0_0010_0000;
  localparam logic [8:0] V_VERT  = 9'b0_0001_0000;
  localparam logic [8:0] V_LOOP  = 9'b0_0000_1000;
  localparam logic [8:0] V_BVTL  = 9'b0_0000_0100;
  localparam logic [8:0] V_TRAP  = 9'b0_0000_0010;
  localparam logic [8:0] V_WASTE = 9'b0_0000_0001;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_LYSIS   = 4'd2,
    S_MIX     = 4'd3,
    S_TRAP    = 4'd4,
    S_WASH    = 4'd5,
    S_ELUTE   = 4'd6,
    S_COLLECT = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  function automatic logic [8:0] valve_map(state_t s);
    logic [8:0] v;
    v = '0;
    case (s)
      S_LOAD:    v = V_HORIZ | V_BVTL;
      S_LYSIS:   v = V_LYSIS | V_VERT;
      S_TRAP:    v = V_LOOP | V_TRAP | V_WASTE;
      S_WASH:    v = V_WASH | V_VERT | V_LOOP | V_TRAP | V_WASTE;
      S_ELUTE:   v = V_ELUTE | V_VERT | V_LOOP | V_TRAP;
      S_COLLECT: v = V_LOOP | V_TRAP;
      default:   v = '0;
    endcase
    return v;
  endfunction

  function automatic logic pump_state(state_t s);
    return (s == S_MIX) || (s == S_TRAP) || (s == S_COLLECT);
  endfunction

  function automatic logic [2:0] pump_seq(logic [2:0] phase);
    logic [2:0] p;
    case (phase)
      3'd0:    p = 3'b101;
      3'd1:    p = 3'b100;
      3'd2:    p = 3'b110;
      3'd3:    p = 3'b010;
      3'd4:    p = 3'b011;
      default: p = 3'b001;
    endcase
    return p;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] ch_idx;
  logic [8:0]       valves;
  logic [N_CH-1:0]  collect_r;
  logic             pump_en;
  logic [2:0]       ph;
  logic [DIV_W-1:0] pdiv;
  logic [2:0]       pump_r;
  logic             busy_r;
  logic             done_r;
  logic             aborted_r;

  logic [CNT_W-1:0] len_lysis, len_mix, len_trap, len_wash, len_elute, len_collect;
  logic [N_CH-1:0]  mask_r;
`ifdef WASH_REPEAT_EN
  logic [3:0]       reps_r;
  logic [3:0]       wash_left;
  logic             wash_gap;
`endif

  state_t           nxt_step;
  logic [CNT_W-1:0] nxt_len;
  logic             nxt_pump;
  logic [IDX_W-1:0] nxt_ch;
  logic             step_end;
  logic [2:0]       ph_next;
  logic             run_req;

  assign run_req = (state == S_IDLE) && bus.start && !bus.abort;

  // Run configuration is only sampled on an accepted start; it never feeds outputs directly.
  always_ff @(posedge clk) begin
    if (run_req) begin
      len_lysis   <= bus.cfg_lysis_len;
      len_mix     <= bus.cfg_mix_len;
      len_trap    <= bus.cfg_trap_len;
      len_wash    <= bus.cfg_wash_len;
      len_elute   <= bus.cfg_elute_len;
      len_collect <= bus.cfg_collect_len;
      mask_r      <= bus.ch_mask;
`ifdef WASH_REPEAT_EN
      reps_r      <= bus.cfg_wash_reps;
`endif
    end
  end

  always_comb begin
    nxt_step = S_IDLE;
    nxt_len  = '0;
    case (state)
      S_LOAD:  begin nxt_step = S_LYSIS; nxt_len = len_lysis; end
      S_LYSIS: begin nxt_step = S_MIX;   nxt_len = len_mix;   end
      S_MIX:   begin nxt_step = S_TRAP;  nxt_len = len_trap;  end
      S_TRAP:  begin nxt_step = S_WASH;  nxt_len = len_wash;  end
      S_WASH:  begin nxt_step = S_ELUTE; nxt_len = len_elute; end
      default: begin nxt_step = S_IDLE;  nxt_len = '0;        end
    endcase
    nxt_pump = pump_state(nxt_step) && (nxt_len != '0);
    nxt_ch   = ch_idx + IDX_W'(1);
    step_end = (cnt <= CNT_W'(1));
    ph_next  = (ph == 3'd5) ? 3'd0 : ph + 3'd1;
  end

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ch_idx    <= '0;
      valves    <= '0;
      collect_r <= '0;
      pump_en   <= 1'b0;
      ph        <= '0;
      pdiv      <= '0;
      pump_r    <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
`ifdef WASH_REPEAT_EN
      wash_left <= '0;
      wash_gap  <= 1'b0;
`endif
    end else begin
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      if (pump_en) begin
        if (pdiv == DIV_LAST) begin
          pdiv   <= '0;
          ph     <= ph_next;
          pump_r <= pump_seq(ph_next);
        end else begin
          pdiv <= pdiv + DIV_W'(1);
        end
      end
      case (state)
        S_IDLE: begin
          if (run_req) begin
            state  <= S_LOAD;
            busy_r <= 1'b1;
            cnt    <= bus.cfg_load_len;
            valves <= (bus.cfg_load_len != '0) ? valve_map(S_LOAD) : '0;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          if (bus.abort) begin
            state     <= S_IDLE;
            busy_r    <= 1'b0;
            aborted_r <= 1'b1;
            valves    <= '0;
            collect_r <= '0;
            pump_en   <= 1'b0;
            pump_r    <= '0;
          end else if (!step_end) begin
            cnt <= cnt - CNT_W'(1);
          end else if (state == S_COLLECT) begin
            if ((ch_idx == LAST_CH) || (len_collect == '0)) begin
              state     <= S_DONE;
              done_r    <= 1'b1;
              busy_r    <= 1'b0;
              valves    <= '0;
              collect_r <= '0;
              pump_en   <= 1'b0;
              pump_r    <= '0;
            end else begin
              ch_idx <= nxt_ch;
              // Unselected channels cost exactly one cycle with every collect valve shut.
              if (mask_r[nxt_ch]) begin
                collect_r <= N_CH'(1) << nxt_ch;
                cnt       <= len_collect;
              end else begin
                collect_r <= '0;
                cnt       <= CNT_W'(1);
              end
            end
          end else if (state == S_ELUTE) begin
            state  <= S_COLLECT;
            ch_idx <= '0;
            if (len_collect == '0) begin
              cnt       <= '0;
              valves    <= '0;
              collect_r <= '0;
              pump_en   <= 1'b0;
              pump_r    <= '0;
            end else begin
              valves  <= valve_map(S_COLLECT);
              pump_en <= 1'b1;
              ph      <= '0;
              pdiv    <= '0;
              pump_r  <= 3'b101;
              if (mask_r[0]) begin
                collect_r <= N_CH'(1);
                cnt       <= len_collect;
              end else begin
                collect_r <= '0;
                cnt       <= CNT_W'(1);
              end
            end
          end
`ifdef WASH_REPEAT_EN
          else if ((state == S_WASH) && wash_gap) begin
            wash_gap <= 1'b0;
            cnt      <= len_wash;
            valves   <= (len_wash != '0) ? valve_map(S_WASH) : '0;
          end else if ((state == S_WASH) && (wash_left > 4'd1)) begin
            wash_gap  <= 1'b1;
            wash_left <= wash_left - 4'd1;
            cnt       <= CNT_W'(1);
            valves    <= '0;
          end
`endif
          else begin
            state   <= nxt_step;
            cnt     <= nxt_len;
            valves  <= (nxt_len != '0) ? valve_map(nxt_step) : '0;
            pump_en <= nxt_pump;
            ph      <= '0;
            pdiv    <= '0;
            pump_r  <= nxt_pump ? 3'b101 : 3'b000;
`ifdef WASH_REPEAT_EN
            wash_left <= (reps_r == 4'd0) ? 4'd1 : reps_r;
            wash_gap  <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  assign bus.lysis_ctl     = valves[8];
  assign bus.wash_ctl      = valves[7];
  assign bus.elute_ctl     = valves[6];
  assign bus.horiz_ctl     = valves[5];
  assign bus.vertical_ctl  = valves[4];
  assign bus.loop_exit_ctl = valves[3];
  assign bus.bead_vtl_ctl  = valves[2];
  assign bus.bead_trap_ctl = valves[1];
  assign bus.waste_ctl     = valves[0];
  assign bus.collect_ctl   = collect_r;
  assign bus.pump          = pump_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.aborted       = aborted_r;
  assign bus.state_o       = state;
endmodule

// File: tb/tb_nucleic_acid_sequencer.sv
// Bench for nucleic_acid_sequencer: vector table, hand-written corner sequences, randomized runs vs a trace model.
// Covers the WASH_REPEAT_EN build as well when that macro is defined.
module tb_nucleic_acid_sequencer;
  localparam int N_CH  = 12;
  localparam int CNT_W = 16;
  localparam int PD    = 4;
`ifdef WASH_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nucleic_acid_sequencer_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();
  nucleic_acid_sequencer #(.N_CH(N_CH), .CNT_W(CNT_W), .PUMP_DIV(PD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0]      st;
    logic [8:0]      v;
    logic [N_CH-1:0] col;
    logic [2:0]      pump;
    logic            busy;
    logic            done;
    logic            abt;
  } obs_t;

  typedef struct {
    logic [6:0][15:0] lens;
    logic [N_CH-1:0]  mask;
    int               abort_at;
    int               e_busy;
    int               e_col;
    int               e_done;
    int               e_abt;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];
  int   n_busy, n_col, n_done, n_abt, n_wash;
  logic [15:0] wash_pat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [6:0][15:0] L(int a, int b, int c, int d, int e, int f, int g);
    return {16'(g), 16'(f), 16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Valve sets from the state table, bit order {lysis,wash,elute,horiz,vert,loop_exit,bead_vtl,bead_trap,waste}.
  function automatic logic [8:0] vmap(int s);
    case (s)
      1:       return 9'b000100100;
      2:       return 9'b100010000;
      4:       return 9'b000001011;
      5:       return 9'b010011011;
      6:       return 9'b001011010;
      7:       return 9'b000001010;
      default: return 9'b000000000;
    endcase
  endfunction

  function automatic logic [2:0] pseq(int k);
    case (k % 6)
      0:       return 3'b101;
      1:       return 3'b100;
      2:       return 3'b110;
      3:       return 3'b010;
      4:       return 3'b011;
      default: return 3'b001;
    endcase
  endfunction

  function automatic obs_t mk(int st, logic [8:0] v, logic [N_CH-1:0] col, logic [2:0] p,
                              logic b, logic d, logic a);
    obs_t o;
    o.st = 4'(st); o.v = v; o.col = col; o.pump = p; o.busy = b; o.done = d; o.abt = a;
    return o;
  endfunction

  function automatic obs_t observe();
    return mk(int'(bus.state_o),
              {bus.lysis_ctl, bus.wash_ctl, bus.elute_ctl, bus.horiz_ctl, bus.vertical_ctl,
               bus.loop_exit_ctl, bus.bead_vtl_ctl, bus.bead_trap_ctl, bus.waste_ctl},
              bus.collect_ctl, bus.pump, bus.busy, bus.done, bus.aborted);
  endfunction

  // Expected cycle-by-cycle output trace of one run, starting with the first cycle after start.
  task automatic build_trace(input logic [6:0][15:0] lens, input logic [N_CH-1:0] mask,
                             input logic [3:0] reps, input int abort_at);
    obs_t full[$];
    int n, reps_eff, t, ncyc;
    exp_q.delete();
    for (int s = 0; s < 6; s++) begin
      n = (lens[s] == 0) ? 1 : int'(lens[s]);
      reps_eff = (REP_EN && s == 4 && reps != 0) ? int'(reps) : 1;
      for (int r = 0; r < reps_eff; r++) begin
        if (r > 0) full.push_back(mk(s + 1, 9'd0, '0, 3'd0, 1'b1, 1'b0, 1'b0));
        for (int j = 0; j < n; j++)
          full.push_back(mk(s + 1, (lens[s] != 0) ? vmap(s + 1) : 9'd0, '0,
                            (lens[s] != 0 && (s == 2 || s == 3)) ? pseq(j / PD) : 3'd0,
                            1'b1, 1'b0, 1'b0));
      end
    end
    if (lens[6] == 0) begin
      full.push_back(mk(7, 9'd0, '0, 3'd0, 1'b1, 1'b0, 1'b0));
    end else begin
      t = 0;
      for (int ch = 0; ch < N_CH; ch++) begin
        ncyc = mask[ch] ? int'(lens[6]) : 1;
        for (int j = 0; j < ncyc; j++) begin
          full.push_back(mk(7, vmap(7), mask[ch] ? (N_CH'(1) << ch) : '0, pseq(t / PD),
                            1'b1, 1'b0, 1'b0));
          t++;
        end
      end
    end
    full.push_back(mk(8, 9'd0, '0, 3'd0, 1'b0, 1'b1, 1'b0));
    if (abort_at >= 0 && abort_at < full.size()) begin
      for (int i = 0; i <= abort_at; i++) exp_q.push_back(full[i]);
      exp_q.push_back(mk(0, 9'd0, '0, 3'd0, 1'b0, 1'b0, full[abort_at].st != 4'd8));
    end else begin
      foreach (full[i]) exp_q.push_back(full[i]);
      exp_q.push_back(mk(0, 9'd0, '0, 3'd0, 1'b0, 1'b0, 1'b0));
    end
    exp_q.push_back(mk(0, 9'd0, '0, 3'd0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic set_cfg(input logic [6:0][15:0] lens, input logic [N_CH-1:0] mask, input logic [3:0] reps);
    bus.cfg_load_len    = lens[0];
    bus.cfg_lysis_len   = lens[1];
    bus.cfg_mix_len     = lens[2];
    bus.cfg_trap_len    = lens[3];
    bus.cfg_wash_len    = lens[4];
    bus.cfg_elute_len   = lens[5];
    bus.cfg_collect_len = lens[6];
    bus.ch_mask         = mask;
`ifdef WASH_REPEAT_EN
    bus.cfg_wash_reps   = reps;
`else
    if (reps != 0) bus.ch_mask = mask;
`endif
  endtask

  task automatic run_case(input string tag, input logic [6:0][15:0] lens, input logic [N_CH-1:0] mask,
                          input logic [3:0] reps, input int abort_at, input bit rnd);
    obs_t o;
    build_trace(lens, mask, reps, abort_at);
    n_busy = 0; n_col = 0; n_done = 0; n_abt = 0; n_wash = 0; wash_pat = '0;
    @(negedge clk);
    set_cfg(lens, mask, reps);
    bus.start = 1'b1;
    bus.abort = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = observe();
      chk($sformatf("%s_cyc%0d", tag, i), o, exp_q[i]);
      n_busy += int'(o.busy);
      n_col  += int'(o.col != '0);
      n_done += int'(o.done);
      n_abt  += int'(o.abt);
      if (o.st == 4'd5) begin
        n_wash++;
        wash_pat = {wash_pat[14:0], bus.wash_ctl};
      end
      if (rnd && i == 0) set_cfg(L($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom),
                                 N_CH'($urandom), 4'($urandom));
      bus.abort = (i == abort_at);
      bus.start = (exp_q[i].st == 4'd3) ||
                  (rnd && exp_q[i].st != 4'd0 && $urandom_range(0, 1) == 1);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int ab;
    tbl[0] = '{L(2, 2, 2, 2, 2, 2, 2),  12'h001, -1, 25, 2,  1, 0};
    tbl[1] = '{L(1, 1, 24, 1, 1, 1, 1), 12'h000, -1, 41, 0,  1, 0};
    tbl[2] = '{L(1, 1, 1, 1, 1, 1, 3),  12'hA05, -1, 26, 12, 1, 0};
    tbl[3] = '{L(2, 2, 2, 2, 2, 2, 2),  12'h001,  8, 9,  0,  0, 1};
    tbl[4] = '{L(0, 0, 0, 0, 0, 0, 0),  12'hFFF, -1, 7,  0,  1, 0};
    tbl[5] = '{L(0, 0, 0, 0, 0, 0, 0),  12'h000,  7, 7,  0,  1, 0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_cfg(L(0, 0, 0, 0, 0, 0, 0), '0, 4'd0);
    repeat (2) @(negedge clk);
    chk("reset_outputs", observe(), '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", observe(), '0);

    for (int k = 0; k < 6; k++) begin
      run_case($sformatf("vec%0d", k), tbl[k].lens, tbl[k].mask, 4'd0, tbl[k].abort_at, 1'b0);
      chk($sformatf("vec%0d_busy", k),    n_busy, tbl[k].e_busy);
      chk($sformatf("vec%0d_collect", k), n_col,  tbl[k].e_col);
      chk($sformatf("vec%0d_done", k),    n_done, tbl[k].e_done);
      chk($sformatf("vec%0d_aborted", k), n_abt,  tbl[k].e_abt);
    end

    // start together with abort in IDLE must not launch a run nor pulse aborted
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    chk("start_abort_idle", observe(), '0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle_next", observe(), '0);

    // asynchronous reset in the middle of a run
    set_cfg(L(3, 3, 3, 3, 3, 3, 3), 12'h0F0, 4'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    o = observe();
    chk("midrun_state", o.st, 4'd3);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", observe(), '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_midrun_reset", observe(), '0);

`ifdef WASH_REPEAT_EN
    run_case("wrep", L(1, 1, 1, 1, 2, 1, 1), 12'h000, 4'd3, -1, 1'b0);
    chk("wash_cycles", n_wash, 8);
    chk("wash_pattern", wash_pat[7:0], 8'b11011011);
    chk("wrep_done", n_done, 1);
`endif

    for (int r = 0; r < 40; r++) begin
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 45)) : -1;
      run_case($sformatf("rnd%0d", r),
               L($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 26), $urandom_range(0, 4),
                 $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3)),
               N_CH'($urandom), 4'($urandom_range(0, 4)), ab, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
